// File: rtl/tcdm_interconnect.sv
// tcdm_interconnect: word-interleaved single-cycle crossbar from cores to TCDM banks,
// per-bank round-robin arbitration and a one-cycle response return path.
module tcdm_rr_arb #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          gnt_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] r_ptr;
    logic          w_found;

    // first requester at or after the pointer, wrapping around
    always_comb begin
        idx_o   = '0;
        win_o   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_i[(int'(r_ptr) + k) % N]) begin
                w_found = 1'b1;
                idx_o   = IW'((int'(r_ptr) + k) % N);
            end
        end
        win_o[idx_o] = w_found;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_ptr <= '0;
        else if (w_found && gnt_i)
            r_ptr <= (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
endmodule

module tcdm_interconnect #(
    parameter  int unsigned NumMaster   = 4,
    parameter  int unsigned BankFact    = 2,
    parameter  int unsigned DataWidth   = 32,
    parameter  int unsigned AddrWidth   = 32,
    parameter  int unsigned MemAddrBits = 8,
    localparam int unsigned NumBanks    = NumMaster * BankFact,
    localparam int unsigned BeWidth     = DataWidth / 8,
    localparam int unsigned Off         = $clog2(BeWidth),
    localparam int unsigned B           = $clog2(NumBanks),
    localparam int unsigned BW          = (B > 0) ? B : 1,
    localparam int unsigned MW          = (NumMaster > 1) ? $clog2(NumMaster) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumMaster-1:0]   req_i,
    input  logic [AddrWidth-1:0]   add_i   [NumMaster],
    input  logic [NumMaster-1:0]   wen_i,
    input  logic [DataWidth-1:0]   wdata_i [NumMaster],
    input  logic [BeWidth-1:0]     be_i    [NumMaster],
    output logic [NumMaster-1:0]   gnt_o,
    output logic [NumMaster-1:0]   vld_o,
    output logic [DataWidth-1:0]   rdata_o [NumMaster],
    output logic [NumBanks-1:0]    req_o,
    input  logic [NumBanks-1:0]    gnt_i,
    output logic [MemAddrBits-1:0] add_o   [NumBanks],
    output logic [NumBanks-1:0]    wen_o,
    output logic [DataWidth-1:0]   wdata_o [NumBanks],
    output logic [BeWidth-1:0]     be_o    [NumBanks],
    input  logic [DataWidth-1:0]   rdata_i [NumBanks]
);
    logic [BW-1:0]          w_bank [NumMaster];
    logic [MemAddrBits-1:0] w_row  [NumMaster];
    logic [NumMaster-1:0]   w_breq [NumBanks];
    logic [NumMaster-1:0]   w_win  [NumBanks];
    logic [MW-1:0]          w_idx  [NumBanks];
    logic [NumMaster-1:0]   r_vld;
    logic [BW-1:0]          r_bank [NumMaster];

    for (genvar m = 0; m < NumMaster; m++) begin : g_mst
        if (B > 0) begin : g_sel
            assign w_bank[m] = add_i[m][B+Off-1:Off];
        end else begin : g_one
            assign w_bank[m] = '0;
        end
        assign w_row[m]   = add_i[m][B+Off+MemAddrBits-1:B+Off];
        assign rdata_o[m] = rdata_i[r_bank[m]];
    end

    always_comb begin
        for (int b = 0; b < NumBanks; b++)
            for (int m = 0; m < NumMaster; m++)
                w_breq[b][m] = req_i[m] && (w_bank[m] == BW'(b));
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        tcdm_rr_arb #(.N(NumMaster)) i_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (w_breq[b]),
            .gnt_i  (gnt_i[b]),
            .win_o  (w_win[b]),
            .idx_o  (w_idx[b])
        );
        assign req_o[b]   = |w_breq[b];
        assign add_o[b]   = req_o[b] ? w_row[w_idx[b]]   : '0;
        assign wen_o[b]   = req_o[b] & wen_i[w_idx[b]];
        assign wdata_o[b] = req_o[b] ? wdata_i[w_idx[b]] : '0;
        assign be_o[b]    = req_o[b] ? be_i[w_idx[b]]    : '0;
    end

    // a master targets exactly one bank, so it can win at most once per cycle
    always_comb begin
        gnt_o = '0;
        for (int m = 0; m < NumMaster; m++)
            gnt_o[m] = w_win[w_bank[m]][m] && gnt_i[w_bank[m]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            for (int m = 0; m < NumMaster; m++) r_bank[m] <= '0;
        end else begin
            r_vld <= gnt_o;
            for (int m = 0; m < NumMaster; m++)
                if (gnt_o[m]) r_bank[m] <= w_bank[m];
        end
    end

    assign vld_o = r_vld;
endmodule

// File: tb/tb_tcdm_interconnect.sv
// tb_tcdm_interconnect: directed and random traffic against a behavioural SRAM per bank,
// with a master-side reference memory checking routed read data and response timing.
module tb_tcdm_interconnect;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req, wen, gnt, vld;
    logic [31:0] add [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic [3:0]  be [4];
    logic [7:0]  breq, bgnt, bwen;
    logic [7:0]  badd [8];
    logic [31:0] bwdata [8];
    logic [31:0] brdata [8];
    logic [3:0]  bbe [8];
    logic [31:0] mem [8][256];
    logic [31:0] refm [2048];
    logic [3:0]  exp_vld = '0, exp_rd = '0, g = '0;
    logic [31:0] exp_data [4];
    int          age [4];
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;
    assign bgnt = breq;

    tcdm_interconnect dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .vld_o(vld), .rdata_o(rdata),
        .req_o(breq), .gnt_i(bgnt), .add_o(badd), .wen_o(bwen), .wdata_o(bwdata),
        .be_o(bbe), .rdata_i(brdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        return 32'h1234_0000 + w * 32'h0100_0193;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = nw[8*i +: 8];
        return old;
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (breq[b] && bgnt[b]) begin
                if (bwen[b]) mem[b][badd[b]] <= merge(mem[b][badd[b]], bwdata[b], bbe[b]);
                else brdata[b] <= mem[b][badd[b]];
            end
        end
    end

    always @(negedge clk) begin : mon
        int n;
        if (!rst_n) begin
            chk("vld_in_reset", vld, 4'h0);
            exp_vld = '0;
        end else begin
            chk("vld_timing", vld, exp_vld);
            for (int m = 0; m < 4; m++)
                if (exp_vld[m] && exp_rd[m]) chk("rdata", rdata[m], exp_data[m]);
            chk("gnt_without_req", gnt & ~req, 4'h0);
            for (int b = 0; b < 8; b++) begin
                n = 0;
                for (int m = 0; m < 4; m++) if (gnt[m] && add[m][4:2] == 3'(b)) n++;
                chk("one_gnt_per_bank", n > 1, 0);
            end
            for (int m = 0; m < 4; m++) begin
                exp_vld[m] = gnt[m];
                exp_rd[m]  = !wen[m];
                if (gnt[m] && wen[m]) refm[add[m][12:2]] = merge(refm[add[m][12:2]], wdata[m], be[m]);
                else if (gnt[m]) exp_data[m] = refm[add[m][12:2]];
            end
        end
    end

    initial begin
        req = '0;
        wen = '0;
        for (int m = 0; m < 4; m++) begin
            add[m] = '0; wdata[m] = '0; be[m] = '0; age[m] = 0;
        end
        for (int w = 0; w < 2048; w++) begin
            mem[w % 8][w / 8] <= init_word(w);
            refm[w] = init_word(w);
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3 chk("reset_vld", vld, 4'h0);
        chk("reset_req_o", breq, 8'h00);

        @(posedge clk); #1 req[0] = 1'b1; add[0] = 32'h124;
        #3 chk("rd_gnt", gnt, 4'b0001);
        chk("rd_req_o", breq, 8'h02);
        chk("rd_add_o", badd[1], 8'h09);
        @(posedge clk); #1 req[0] = 1'b0;
        #3 chk("rd_vld", vld[0], 1'b1);
        chk("rd_data", rdata[0], init_word(73));

        @(posedge clk); #1 req[2] = 1'b1; add[2] = 32'h14; wen[2] = 1'b1;
        wdata[2] = 32'hDEADBEEF; be[2] = 4'b0101;
        #3 chk("wr_gnt", gnt, 4'b0100);
        chk("wr_req_o", breq, 8'h20);
        chk("wr_wen_o", bwen[5], 1'b1);
        chk("wr_wdata_o", bwdata[5], 32'hDEADBEEF);
        chk("wr_be_o", bbe[5], 4'b0101);
        chk("wr_add_o", badd[5], 8'h00);
        @(posedge clk); #1 wen[2] = 1'b0;
        #3 chk("wr_vld", vld[2], 1'b1);
        @(posedge clk); #1 req[2] = 1'b0;
        #3 chk("wr_readback", rdata[2], (init_word(5) & 32'hFF00FF00) | 32'h00AD00EF);

        @(posedge clk); #1 req[1:0] = 2'b11; add[0] = 32'h0C; add[1] = 32'h2C;
        for (int i = 0; i < 4; i++) begin
            #3 chk("cf_gnt", gnt, i[0] ? 4'b0010 : 4'b0001);
            if (i > 0) chk("cf_vld", vld, i[0] ? 4'b0001 : 4'b0010);
            @(posedge clk); #1;
        end
        req = '0;
        #3 chk("cf_vld_last", vld, 4'b0010);

        for (int m = 0; m < 4; m++) add[m] = 32'(m * 8);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1 req = 4'hF;
            #3 chk("perm_gnt", gnt, 4'hF);
        end
        @(posedge clk); #1 req = '0;

        foreach (age[m]) age[m] = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3000; i++) begin
                @(posedge clk); #1;
                for (int m = 0; m < 4; m++) begin
                    if (!req[m] || g[m]) begin
                        req[m]   = $urandom_range(99) < (p == 0 ? 25 : p == 1 ? 50 : 100);
                        add[m]   = ($urandom & 32'hFFFFE000) | 32'($urandom_range(63) << 2) | 32'($urandom_range(3));
                        wen[m]   = 1'($urandom_range(1));
                        wdata[m] = $urandom;
                        be[m]    = 4'($urandom_range(15));
                    end
                end
                #3 g = gnt;
                for (int m = 0; m < 4; m++) begin
                    age[m] = (req[m] && !g[m]) ? age[m] + 1 : 0;
                    chk("starvation", age[m] > 3, 0);
                end
            end
        end

        @(posedge clk); #1 req = 4'b0001; add[0] = 32'h124; wen = '0;
        #3 chk("rs_gnt", gnt[0], 1'b1);
        @(posedge clk); #1 chk("rs_vld_before", vld[0], 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("rs_vld_now", vld, 4'h0);
        chk("rs_gnt_transparent", gnt[0], 1'b1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1 req = '0;
        #3 chk("rs_vld_after", vld[0], 1'b1);
        chk("rs_data_after", rdata[0], init_word(73));
        @(posedge clk); #4;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
